// File: rtl/instruction_fetch.sv
// -----------------------------------------------------------------------------
// instruction_fetch
//
// Fetch stage feeding decode and the immediate generator. Holds the program
// counter, issues one word-aligned read at a time to instruction memory and
// presents each returned instruction, tagged with its PC, over a valid/ready
// handshake. A downstream redirect loads a new PC and squashes whatever fetch
// is in flight or held. A misaligned redirect target parks the stage in a
// fault state that only reset leaves.
//
// Ports:
//   clk             in   1   rising-edge clock
//   reset           in   1   synchronous, active-high reset
//   imem_req        out  1   read request to instruction memory
//   imem_addr       out  32  word-aligned byte address of the request
//   imem_gnt        in   1   memory accepts the request this cycle
//   imem_rvalid     in   1   read data valid
//   imem_rdata      in   32  instruction word from memory
//   redirect_valid  in   1   load redirect_target as the new PC this cycle
//   redirect_target in   32  new PC
//   inst_valid      out  1   inst_out / inst_pc hold a valid instruction
//   inst_ready      in   1   decode accepts the held instruction
//   inst_out        out  32  instruction (NOP_INST when nothing is held)
//   inst_pc         out  32  PC of inst_out
//   fetch_fault     out  1   sticky misaligned-redirect flag
// -----------------------------------------------------------------------------
module instruction_fetch #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter logic [31:0] NOP_INST = 32'h0000_0013
) (
    input  logic        clk,
    input  logic        reset,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_gnt,
    input  logic        imem_rvalid,
    input  logic [31:0] imem_rdata,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_target,
    output logic        inst_valid,
    input  logic        inst_ready,
    output logic [31:0] inst_out,
    output logic [31:0] inst_pc,
    output logic        fetch_fault
);

    typedef enum logic [1:0] {
        ST_REQ   = 2'd0,
        ST_WAIT  = 2'd1,
        ST_HOLD  = 2'd2,
        ST_FAULT = 2'd3
    } state_t;

    state_t      state_r, state_s;
    logic [31:0] pc_r, pc_s;
    logic [31:0] req_pc_r, req_pc_s;
    logic        kill_r, kill_s;
    logic        inst_valid_r, inst_valid_s;
    logic [31:0] inst_out_r, inst_out_s;
    logic [31:0] inst_pc_r, inst_pc_s;
    logic        fetch_fault_r, fetch_fault_s;
    logic        redir_ok_s, redir_bad_s;

    // State and datapath registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r       <= ST_REQ;
            pc_r          <= RESET_PC;
            req_pc_r      <= 32'h0000_0000;
            kill_r        <= 1'b0;
            inst_valid_r  <= 1'b0;
            inst_out_r    <= NOP_INST;
            inst_pc_r     <= 32'h0000_0000;
            fetch_fault_r <= 1'b0;
        end else begin
            state_r       <= state_s;
            pc_r          <= pc_s;
            req_pc_r      <= req_pc_s;
            kill_r        <= kill_s;
            inst_valid_r  <= inst_valid_s;
            inst_out_r    <= inst_out_s;
            inst_pc_r     <= inst_pc_s;
            fetch_fault_r <= fetch_fault_s;
        end
    end

    // Next-state and next-datapath logic; redirects take priority over
    // grant, rvalid and ready in the same cycle.
    always_comb begin
        state_s       = state_r;
        pc_s          = pc_r;
        req_pc_s      = req_pc_r;
        kill_s        = kill_r;
        inst_valid_s  = inst_valid_r;
        inst_out_s    = inst_out_r;
        inst_pc_s     = inst_pc_r;
        fetch_fault_s = fetch_fault_r;

        redir_ok_s  = redirect_valid & (redirect_target[1:0] == 2'b00);
        redir_bad_s = redirect_valid & (redirect_target[1:0] != 2'b00);

        if (state_r == ST_FAULT) begin
            // Terminal until reset: redirects and responses are ignored.
            state_s = ST_FAULT;
        end else if (redir_bad_s) begin
            // PC is deliberately left untouched so the last good address
            // remains visible for debug.
            state_s       = ST_FAULT;
            fetch_fault_s = 1'b1;
            inst_valid_s  = 1'b0;
            inst_out_s    = NOP_INST;
            kill_s        = 1'b0;
        end else begin
            case (state_r)
                ST_REQ: begin
                    if (redir_ok_s) begin
                        pc_s = redirect_target;
                        if (imem_gnt) begin
                            // The grant already went out for the old PC; its
                            // response must be swallowed before refetching.
                            kill_s  = 1'b1;
                            state_s = ST_WAIT;
                        end else begin
                            state_s = ST_REQ;
                        end
                    end else if (imem_gnt) begin
                        req_pc_s = pc_r;
                        pc_s     = pc_r + 32'd4;
                        state_s  = ST_WAIT;
                    end else begin
                        state_s = ST_REQ;
                    end
                end
                ST_WAIT: begin
                    if (redir_ok_s) begin
                        pc_s = redirect_target;
                        if (imem_rvalid) begin
                            kill_s  = 1'b0;
                            state_s = ST_REQ;
                        end else begin
                            kill_s  = 1'b1;
                            state_s = ST_WAIT;
                        end
                    end else if (imem_rvalid) begin
                        if (kill_r) begin
                            kill_s  = 1'b0;
                            state_s = ST_REQ;
                        end else begin
                            inst_out_s   = imem_rdata;
                            inst_pc_s    = req_pc_r;
                            inst_valid_s = 1'b1;
                            state_s      = ST_HOLD;
                        end
                    end else begin
                        state_s = ST_WAIT;
                    end
                end
                ST_HOLD: begin
                    if (redir_ok_s) begin
                        pc_s         = redirect_target;
                        inst_valid_s = 1'b0;
                        inst_out_s   = NOP_INST;
                        state_s      = ST_REQ;
                    end else if (inst_ready) begin
                        inst_valid_s = 1'b0;
                        inst_out_s   = NOP_INST;
                        state_s      = ST_REQ;
                    end else begin
                        state_s = ST_HOLD;
                    end
                end
                default: begin
                    // Unreachable encoding: fail safe into the fault state.
                    state_s       = ST_FAULT;
                    fetch_fault_s = 1'b1;
                    inst_valid_s  = 1'b0;
                    inst_out_s    = NOP_INST;
                end
            endcase
        end
    end

    // Output decode from registers; reset suppresses the request at once so
    // memory never sees a request during a reset cycle.
    always_comb begin
        imem_req    = (state_r == ST_REQ) & ~reset;
        imem_addr   = pc_r;
        inst_valid  = inst_valid_r;
        inst_out    = inst_out_r;
        inst_pc     = inst_pc_r;
        fetch_fault = fetch_fault_r;
    end

endmodule

// File: tb/tb_instruction_fetch.sv
module tb_instruction_fetch;

    localparam logic [31:0] NOP = 32'h0000_0013;

    logic        clk = 1'b0;
    logic        reset;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_gnt;
    logic        imem_rvalid;
    logic [31:0] imem_rdata;
    logic        redirect_valid;
    logic [31:0] redirect_target;
    logic        inst_valid;
    logic        inst_ready;
    logic [31:0] inst_out;
    logic [31:0] inst_pc;
    logic        fetch_fault;

    // second instance with a reset PC at the top of the address space
    logic        w_req;
    logic [31:0] w_addr;
    logic        w_gnt = 1'b0;
    logic        w_rvalid = 1'b0;
    logic [31:0] w_rdata = 32'h0000_0000;
    logic        w_valid;
    logic [31:0] w_out;
    logic [31:0] w_pc;
    logic        w_fault;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    instruction_fetch dut (
        .clk(clk), .reset(reset),
        .imem_req(imem_req), .imem_addr(imem_addr), .imem_gnt(imem_gnt),
        .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
        .redirect_valid(redirect_valid), .redirect_target(redirect_target),
        .inst_valid(inst_valid), .inst_ready(inst_ready),
        .inst_out(inst_out), .inst_pc(inst_pc), .fetch_fault(fetch_fault)
    );

    instruction_fetch #(.RESET_PC(32'hFFFF_FFFC), .NOP_INST(32'h0000_0013)) dut_wrap (
        .clk(clk), .reset(reset),
        .imem_req(w_req), .imem_addr(w_addr), .imem_gnt(w_gnt),
        .imem_rvalid(w_rvalid), .imem_rdata(w_rdata),
        .redirect_valid(1'b0), .redirect_target(32'h0000_0000),
        .inst_valid(w_valid), .inst_ready(1'b1),
        .inst_out(w_out), .inst_pc(w_pc), .fetch_fault(w_fault)
    );

    typedef struct {
        logic        gnt;
        logic        rvalid;
        logic [31:0] rdata;
        logic        ready;
        logic        exp_req;
        logic [31:0] exp_addr;
        logic        exp_valid;
        logic [31:0] exp_out;
        logic [31:0] exp_pc;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(input logic g, input logic rv, input logic [31:0] rd,
                                input logic rdy, input logic er, input logic [31:0] ea,
                                input logic ev, input logic [31:0] eo, input logic [31:0] ep);
        vec_t v;
        v.gnt = g; v.rvalid = rv; v.rdata = rd; v.ready = rdy;
        v.exp_req = er; v.exp_addr = ea; v.exp_valid = ev; v.exp_out = eo; v.exp_pc = ep;
        return v;
    endfunction

    // memory contents used by the randomized phase
    function automatic logic [31:0] memf(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h5A5A_0013;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic chk1(input string name, input logic act, input logic exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %b expected %b", name, act, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        imem_gnt = 1'b0; imem_rvalid = 1'b0; imem_rdata = 32'h0000_0000;
        redirect_valid = 1'b0; redirect_target = 32'h0000_0000; inst_ready = 1'b1;
    endtask

    task automatic step(input logic g, input logic rv, input logic [31:0] rd,
                        input logic rdir, input logic [31:0] tgt, input logic rdy);
        imem_gnt = g; imem_rvalid = rv; imem_rdata = rd;
        redirect_valid = rdir; redirect_target = tgt; inst_ready = rdy;
        cyc();
        idle_inputs();
    endtask

    task automatic do_reset();
        idle_inputs();
        reset = 1'b1;
        cyc();
        chk1("reset_req_low", imem_req, 1'b0);
        cyc();
        reset = 1'b0;
        #1;
        chk1("rst_req", imem_req, 1'b1);
        chk("rst_addr", imem_addr, 32'h0000_0000);
        chk1("rst_valid", inst_valid, 1'b0);
        chk("rst_out", inst_out, NOP);
        chk("rst_pc", inst_pc, 32'h0000_0000);
        chk1("rst_fault", fetch_fault, 1'b0);
    endtask

    // randomized-phase model state
    logic [31:0] mpc, maddr, tgt, rd, tmp;
    logic        mo, mkill, g, rv, rdir, rdy, grant, hs, exp_req;
    int          mcnt, delivered;
    logic [31:0] qpc[$];
    logic [31:0] qdat[$];

    initial begin
        reset = 1'b1;
        idle_inputs();
        do_reset();

        // zero-wait fetch of 0x0, 0x4, 0x8 followed by 5 cycles of backpressure
        vecs.push_back(mk(1'b1, 1'b0, 32'h0,          1'b1, 1'b1, 32'h0, 1'b0, NOP, 32'h0));
        vecs.push_back(mk(1'b0, 1'b1, 32'h0010_0093, 1'b1, 1'b0, 32'h4, 1'b0, NOP, 32'h0));
        vecs.push_back(mk(1'b0, 1'b0, 32'h0,          1'b1, 1'b0, 32'h4, 1'b1, 32'h0010_0093, 32'h0));
        vecs.push_back(mk(1'b1, 1'b0, 32'h0,          1'b1, 1'b1, 32'h4, 1'b0, NOP, 32'h0));
        vecs.push_back(mk(1'b0, 1'b1, 32'h0020_0113, 1'b1, 1'b0, 32'h8, 1'b0, NOP, 32'h0));
        vecs.push_back(mk(1'b0, 1'b0, 32'h0,          1'b1, 1'b0, 32'h8, 1'b1, 32'h0020_0113, 32'h4));
        vecs.push_back(mk(1'b1, 1'b0, 32'h0,          1'b1, 1'b1, 32'h8, 1'b0, NOP, 32'h0));
        vecs.push_back(mk(1'b0, 1'b1, 32'h0050_0093, 1'b1, 1'b0, 32'hC, 1'b0, NOP, 32'h0));
        for (int i = 0; i < 5; i++)
            vecs.push_back(mk(1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 32'hC, 1'b1, 32'h0050_0093, 32'h8));
        vecs.push_back(mk(1'b0, 1'b0, 32'h0,          1'b1, 1'b0, 32'hC, 1'b1, 32'h0050_0093, 32'h8));
        vecs.push_back(mk(1'b0, 1'b0, 32'h0,          1'b1, 1'b1, 32'hC, 1'b0, NOP, 32'h0));
        vecs.push_back(mk(1'b0, 1'b0, 32'h0,          1'b1, 1'b1, 32'hC, 1'b0, NOP, 32'h0));

        for (int i = 0; i < vecs.size(); i++) begin
            chk1($sformatf("vec%0d_req", i), imem_req, vecs[i].exp_req);
            chk($sformatf("vec%0d_addr", i), imem_addr, vecs[i].exp_addr);
            chk1($sformatf("vec%0d_valid", i), inst_valid, vecs[i].exp_valid);
            chk($sformatf("vec%0d_out", i), inst_out, vecs[i].exp_out);
            if (vecs[i].exp_valid)
                chk($sformatf("vec%0d_pc", i), inst_pc, vecs[i].exp_pc);
            imem_gnt = vecs[i].gnt; imem_rvalid = vecs[i].rvalid;
            imem_rdata = vecs[i].rdata; inst_ready = vecs[i].ready;
            cyc();
        end
        idle_inputs();

        // redirect to 0x100 while waiting; the late 0xDEADBEEF must be dropped
        do_reset();
        step(1'b1, 1'b0, 32'h0, 1'b0, 32'h0, 1'b1);
        step(1'b0, 1'b0, 32'h0, 1'b1, 32'h0000_0100, 1'b1);
        step(1'b0, 1'b1, 32'hDEAD_BEEF, 1'b0, 32'h0, 1'b1);
        chk1("wredir_valid", inst_valid, 1'b0);
        chk1("wredir_req", imem_req, 1'b1);
        chk("wredir_addr", imem_addr, 32'h0000_0100);
        step(1'b1, 1'b0, 32'h0, 1'b0, 32'h0, 1'b1);
        step(1'b0, 1'b1, 32'h0030_0113, 1'b0, 32'h0, 1'b1);
        chk1("wredir_valid2", inst_valid, 1'b1);
        chk("wredir_pc", inst_pc, 32'h0000_0100);
        chk("wredir_out", inst_out, 32'h0030_0113);

        // redirect to 0x200 in the same cycle as the grant for 0x8
        do_reset();
        for (int i = 0; i < 2; i++) begin
            step(1'b1, 1'b0, 32'h0, 1'b0, 32'h0, 1'b1);
            step(1'b0, 1'b1, 32'h0000_0013, 1'b0, 32'h0, 1'b1);
            step(1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b1);
        end
        chk("gredir_addr8", imem_addr, 32'h0000_0008);
        step(1'b1, 1'b0, 32'h0, 1'b1, 32'h0000_0200, 1'b1);
        chk1("gredir_wait", imem_req, 1'b0);
        step(1'b0, 1'b1, 32'h1111_1111, 1'b0, 32'h0, 1'b1);
        chk1("gredir_drop", inst_valid, 1'b0);
        chk1("gredir_req", imem_req, 1'b1);
        chk("gredir_addr", imem_addr, 32'h0000_0200);
        step(1'b1, 1'b0, 32'h0, 1'b0, 32'h0, 1'b1);
        step(1'b0, 1'b1, 32'h2222_2222, 1'b0, 32'h0, 1'b1);
        chk1("gredir_valid", inst_valid, 1'b1);
        chk("gredir_pc", inst_pc, 32'h0000_0200);
        chk("gredir_out", inst_out, 32'h2222_2222);

        // misaligned redirect while holding an instruction
        do_reset();
        step(1'b1, 1'b0, 32'h0, 1'b0, 32'h0, 1'b1);
        step(1'b0, 1'b1, 32'h0040_0093, 1'b0, 32'h0, 1'b0);
        step(1'b0, 1'b0, 32'h0, 1'b1, 32'h0000_0102, 1'b0);
        chk1("fault_flag", fetch_fault, 1'b1);
        chk1("fault_valid", inst_valid, 1'b0);
        chk("fault_out", inst_out, NOP);
        for (int i = 0; i < 6; i++) begin
            chk1($sformatf("fault_req%0d", i), imem_req, 1'b0);
            chk($sformatf("fault_addr%0d", i), imem_addr, 32'h0000_0004);
            step(1'b1, 1'b1, 32'h1234_5678, 1'b1, 32'h0000_0300, 1'b1);
        end
        chk1("fault_sticky", fetch_fault, 1'b1);
        chk1("fault_novalid", inst_valid, 1'b0);
        do_reset();

        // reset wins over a simultaneous redirect
        step(1'b1, 1'b0, 32'h0, 1'b0, 32'h0, 1'b1);
        reset = 1'b1; redirect_valid = 1'b1; redirect_target = 32'h0000_0400;
        cyc();
        reset = 1'b0; idle_inputs();
        #1;
        chk("rstredir_addr", imem_addr, 32'h0000_0000);
        chk1("rstredir_req", imem_req, 1'b1);

        // wrap-around instance: 0xFFFFFFFC then 0x0
        do_reset();
        chk1("wrap_req", w_req, 1'b1);
        chk("wrap_addr0", w_addr, 32'hFFFF_FFFC);
        w_gnt = 1'b1; cyc(); w_gnt = 1'b0;
        w_rvalid = 1'b1; w_rdata = 32'hABCD_0013; cyc(); w_rvalid = 1'b0;
        chk1("wrap_valid", w_valid, 1'b1);
        chk("wrap_pc", w_pc, 32'hFFFF_FFFC);
        chk("wrap_out", w_out, 32'hABCD_0013);
        cyc();
        chk1("wrap_req2", w_req, 1'b1);
        chk("wrap_addr1", w_addr, 32'h0000_0000);
        chk1("wrap_fault", w_fault, 1'b0);

        // randomized traffic against a transaction-level model
        do_reset();
        mpc = 32'h0000_0000; mo = 1'b0; mkill = 1'b0; mcnt = 0; delivered = 0;
        maddr = 32'h0000_0000;
        qpc.delete(); qdat.delete();
        for (int c = 0; c < 3000; c++) begin
            exp_req = !mo && (qpc.size() == 0);
            chk1("rnd_req", imem_req, exp_req);
            if (exp_req)
                chk("rnd_addr", imem_addr, mpc);
            if (qpc.size() != 0) begin
                chk1("rnd_valid", inst_valid, 1'b1);
                chk("rnd_out", inst_out, qdat[0]);
                chk("rnd_pc", inst_pc, qpc[0]);
            end else begin
                chk1("rnd_valid", inst_valid, 1'b0);
                chk("rnd_nop", inst_out, NOP);
            end
            chk1("rnd_fault", fetch_fault, 1'b0);

            g = ($urandom_range(0, 9) < 6);
            rdy = ($urandom_range(0, 9) < 7);
            rdir = ($urandom_range(0, 11) == 0);
            tmp = $urandom;
            tgt = ($urandom_range(0, 3) == 0) ? (32'hFFFF_FFF0 | (tmp & 32'h0000_000C))
                                              : (tmp & 32'hFFFF_FFFC);
            rv = 1'b0;
            rd = $urandom;
            if (mo) begin
                if (mcnt == 0) begin
                    rv = 1'b1;
                    rd = memf(maddr);
                end else begin
                    mcnt--;
                end
            end else if ($urandom_range(0, 9) == 0) begin
                rv = 1'b1;
            end
            imem_gnt = g; imem_rvalid = rv; imem_rdata = rd;
            redirect_valid = rdir; redirect_target = tgt; inst_ready = rdy;

            grant = imem_req && g;
            hs = (qpc.size() != 0) && rdy && !rdir;
            if (hs) begin
                void'(qpc.pop_front());
                void'(qdat.pop_front());
                delivered++;
            end
            if (mo && rv) begin
                if (!mkill && !rdir) begin
                    qpc.push_back(maddr);
                    qdat.push_back(memf(maddr));
                end
                mo = 1'b0;
                mkill = 1'b0;
            end else if (mo && rdir) begin
                mkill = 1'b1;
            end
            if (grant) begin
                mo = 1'b1;
                maddr = mpc;
                mkill = rdir;
                mcnt = $urandom_range(0, 2);
            end
            if (rdir) begin
                qpc.delete();
                qdat.delete();
                mpc = tgt;
            end else if (grant) begin
                mpc = mpc + 32'd4;
            end
            cyc();
        end
        idle_inputs();
        chk1("rnd_progress", delivered > 100, 1'b1);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
